// File: rtl/dot_feeder_pkg.sv
// Shared constants for the feeder/collector family: widths, address layout,
// timeout counter width and the feeder state encoding.
package dot_feeder_pkg;

   localparam int DATA_LEN = 16;
   localparam int VEC_LEN  = 36;
   localparam int VEC_W    = VEC_LEN * DATA_LEN;
   localparam int CS_W     = 4;
   localparam int PHASE_W  = 3;
   localparam int ADDR_W   = CS_W + PHASE_W;
   localparam int TO_W     = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   // Operand/result address layout is {cs, phase}.
   function automatic logic [ADDR_W-1:0] pack_addr(input logic [CS_W-1:0] cs,
                                                   input logic [PHASE_W-1:0] phase);
      return {cs, phase};
   endfunction

endpackage

// File: rtl/dot_feeder_if.sv
// Dot-channel connection: the feeder is the master, the channel the slave.
interface dot_feeder_if;
   import dot_feeder_pkg::*;

   logic [VEC_W-1:0]    d;
   logic                dc_load;
   logic                ws_load;
   logic [CS_W-1:0]     cs;
   logic [PHASE_W-1:0]  phase;
   logic                dc_valid;
   logic [DATA_LEN-1:0] dc_q;

   modport master (
      output d, dc_load, ws_load, cs, phase,
      input  dc_valid, dc_q
   );

   modport slave (
      input  d, dc_load, ws_load, cs, phase,
      output dc_valid, dc_q
   );

endinterface

// File: rtl/dot_feeder_idx.sv
// Nested cs/phase counter: phase is the inner loop, cs the outer, with a
// flag marking the final pair of the sweep.
module dot_feeder_idx
   import dot_feeder_pkg::*;
#(
   parameter int CS_NUM    = 16,
   parameter int PHASE_NUM = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               advance,
   output logic [CS_W-1:0]    cs,
   output logic [PHASE_W-1:0] phase,
   output logic               last
);

   localparam logic [CS_W-1:0]    CS_LAST    = CS_W'(CS_NUM - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_NUM - 1);

   assign last = (cs == CS_LAST) && (phase == PHASE_LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cs    <= '0;
         phase <= '0;
      end else if (advance) begin
         if (phase == PHASE_LAST) begin
            phase <= '0;
            cs    <= (cs == CS_LAST) ? '0 : cs + 1'b1;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dot_feeder.sv
// Dot-channel initiator: fetches one operand vector per (cs, phase) pair, runs
// it through the channel and emits one result beat. DOT_FEEDER_RELU_EN clamps
// negative results to zero.
module dot_feeder
   import dot_feeder_pkg::*;
#(
   parameter int CS_NUM    = 16,
   parameter int PHASE_NUM = 8,
   parameter int TIMEOUT   = 63
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                src_req,
   output logic [ADDR_W-1:0]   src_addr,
   input  logic                src_valid,
   input  logic [VEC_W-1:0]    src_data,
   dot_feeder_if.master        dc,
   output logic                res_valid,
   output logic [DATA_LEN-1:0] res_data,
   output logic [ADDR_W-1:0]   res_addr,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t              state;
   state_t              state_nx;
   logic                fetch_sent;
   logic [TO_W-1:0]     to_cnt;
   logic [VEC_W-1:0]    d_q;
   logic [DATA_LEN-1:0] res_q;
   logic [DATA_LEN-1:0] res_shaped;
   logic                err_q;
   logic                load;
   logic                sweep_start;
   logic                accept_src;
   logic                accept_q;
   logic                timeout_hit;
   logic                idx_adv;
   logic [CS_W-1:0]     cs;
   logic [PHASE_W-1:0]  phase;
   logic                last;

   dot_feeder_idx #(
      .CS_NUM    (CS_NUM),
      .PHASE_NUM (PHASE_NUM)
   ) u_idx (
      .clk     (clk),
      .rst     (rst),
      .clear   (sweep_start),
      .advance (idx_adv),
      .cs      (cs),
      .phase   (phase),
      .last    (last)
   );

`ifdef DOT_FEEDER_RELU_EN
   always_comb begin
      res_shaped = dc.dc_q[DATA_LEN-1] ? '0 : dc.dc_q;
   end
`else
   always_comb begin
      res_shaped = dc.dc_q;
   end
`endif

   // dc_valid is tested before the timeout so a result arriving on the
   // terminal count is still taken.
   always_comb begin
      state_nx    = state;
      src_req     = 1'b0;
      load        = 1'b0;
      res_valid   = 1'b0;
      done        = 1'b0;
      sweep_start = 1'b0;
      accept_src  = 1'b0;
      accept_q    = 1'b0;
      timeout_hit = 1'b0;
      idx_adv     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               sweep_start = 1'b1;
               state_nx    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            src_req = !fetch_sent;
            if (src_valid) begin
               accept_src = 1'b1;
               state_nx   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load = 1'b1;
            if (dc.dc_valid) begin
               accept_q = 1'b1;
               state_nx = ST_CAPTURE;
            end else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nx    = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            res_valid = 1'b1;
            idx_adv   = 1'b1;
            state_nx  = last ? ST_DONE : ST_FETCH;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // fetch_sent is low only in the first cycle of each FETCH visit, so the
   // request is a single-cycle pulse however long the source takes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         fetch_sent <= 1'b0;
         to_cnt     <= '0;
         d_q        <= '0;
         res_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nx;
         fetch_sent <= (state == ST_FETCH);
         to_cnt     <= (state == ST_LOAD) ? to_cnt + 1'b1 : '0;
         if (accept_src) begin
            d_q <= src_data;
         end
         if (accept_q) begin
            res_q <= res_shaped;
         end
         if (sweep_start) begin
            err_q <= 1'b0;
         end else if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign src_addr   = pack_addr(cs, phase);
   assign res_addr   = pack_addr(cs, phase);
   assign res_data   = res_q;
   assign busy       = (state != ST_IDLE);
   assign err        = err_q;
   assign dc.d       = d_q;
   assign dc.dc_load = load;
   assign dc.ws_load = load;
   assign dc.cs      = cs;
   assign dc.phase   = phase;

endmodule

// File: tb/tb_dot_feeder.sv
// Directed bench for dot_feeder on a 2x2 sweep: source answers 2 cycles after
// src_req, channel answers 6 cycles after dc_load rises.
module tb_dot_feeder;
   import dot_feeder_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                src_req;
   logic [ADDR_W-1:0]   src_addr;
   logic                src_valid;
   logic [VEC_W-1:0]    src_data;
   logic                res_valid;
   logic [DATA_LEN-1:0] res_data;
   logic [ADDR_W-1:0]   res_addr;
   logic                busy;
   logic                done;
   logic                err;

   int n_checks = 0;
   int n_errors = 0;

   dot_feeder_if ch ();

   dot_feeder #(
      .CS_NUM    (2),
      .PHASE_NUM (2),
      .TIMEOUT   (63)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_req   (src_req),
      .src_addr  (src_addr),
      .src_valid (src_valid),
      .src_data  (src_data),
      .dc        (ch.master),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_addr  (res_addr),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_a(input string tag, input logic [ADDR_W-1:0] obs,
                          input logic [ADDR_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_q(input string tag, input logic [DATA_LEN-1:0] obs,
                          input logic [DATA_LEN-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_v(input string tag, input logic [VEC_W-1:0] obs,
                          input logic [VEC_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full pair: wait for the request, answer it, let the channel answer,
   // check the result beat and what follows it.
   task automatic run_pair(input logic [ADDR_W-1:0] addr, input logic [DATA_LEN-1:0] q,
                           input logic [DATA_LEN-1:0] exp_res, input bit spurious,
                           input bit last);
      logic [VEC_W-1:0] vec;
      logic             seen;
      vec  = {VEC_LEN{{9'h0A5, addr}}};
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (src_req) begin
            seen = 1'b1;
            break;
         end
         tick;
      end
      check1("src_req_seen", seen, 1'b1);
      check_a("src_addr", src_addr, addr);
      check1("busy_fetch", busy, 1'b1);
      if (spurious) ch.dc_valid = 1'b1;
      tick;
      ch.dc_valid = 1'b0;
      check1("src_req_once", src_req, 1'b0);
      check1("fetch_no_load", ch.dc_load, 1'b0);
      check1("fetch_no_res", res_valid, 1'b0);
      tick;
      src_valid = 1'b1;
      src_data  = vec;
      tick;
      src_valid = 1'b0;
      src_data  = ~vec;
      check1("dc_load_rise", ch.dc_load, 1'b1);
      check1("ws_load_rise", ch.ws_load, 1'b1);
      check_v("d_loaded", ch.d, vec);
      check_a("ch_idx", {ch.cs, ch.phase}, addr);
      for (int i = 1; i <= 6; i++) begin
         if (spurious && i == 2) begin
            src_valid = 1'b1;
            start     = 1'b1;
         end
         tick;
         src_valid = 1'b0;
         start     = 1'b0;
         check1("dc_load_hold", ch.dc_load, 1'b1);
         check_v("d_stable", ch.d, vec);
      end
      ch.dc_valid = 1'b1;
      ch.dc_q     = q;
      tick;
      ch.dc_valid = 1'b0;
      ch.dc_q     = 16'h5A5A;
      check1("res_valid", res_valid, 1'b1);
      check1("dc_load_gap", ch.dc_load, 1'b0);
      check1("ws_load_gap", ch.ws_load, 1'b0);
      check_a("res_addr", res_addr, addr);
      check_q("res_data", res_data, exp_res);
      tick;
      check1("res_valid_pulse", res_valid, 1'b0);
      if (last) begin
         check1("done_pulse", done, 1'b1);
         tick;
         check1("done_once", done, 1'b0);
         check1("busy_after_done", busy, 1'b0);
      end else begin
         check1("next_src_req", src_req, 1'b1);
         check1("next_gap_load", ch.dc_load, 1'b0);
      end
   endtask

   initial begin
      int                  cnt;
      logic                saw_done;
      logic [DATA_LEN-1:0] neg_exp;
`ifdef DOT_FEEDER_RELU_EN
      neg_exp = 16'h0000;
`else
      neg_exp = 16'hFFF0;
`endif
      rst         = 1'b1;
      start       = 1'b0;
      src_valid   = 1'b0;
      src_data    = '0;
      ch.dc_valid = 1'b0;
      ch.dc_q     = '0;
      tick;
      tick;
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_err", err, 1'b0);
      check1("rst_src_req", src_req, 1'b0);
      check1("rst_dc_load", ch.dc_load, 1'b0);
      check1("rst_res_valid", res_valid, 1'b0);
      check_a("rst_src_addr", src_addr, 7'h00);
      check_v("rst_d", ch.d, '0);
      check_q("rst_res_data", res_data, 16'h0000);
      rst = 1'b0;
      tick;
      check1("idle_hold", busy, 1'b0);

      $display("[TB] clean sweep");
      start = 1'b1;
      tick;
      start = 1'b0;
      check1("busy_start", busy, 1'b1);
      check1("err_start", err, 1'b0);
      run_pair(7'h00, 16'h1234, 16'h1234, 1'b0, 1'b0);
      run_pair(7'h01, 16'hFFF0, neg_exp,  1'b1, 1'b0);
      run_pair(7'h08, 16'h0042, 16'h0042, 1'b0, 1'b0);
      run_pair(7'h09, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
      tick;
      check1("done_stays_low", done, 1'b0);

      $display("[TB] timeout sweep");
      start = 1'b1;
      tick;
      start = 1'b0;
      check1("to_src_req", src_req, 1'b1);
      tick;
      tick;
      src_valid = 1'b1;
      src_data  = {VEC_LEN{16'h0BAD}};
      tick;
      src_valid = 1'b0;
      cnt       = 0;
      saw_done  = 1'b0;
      while (ch.dc_load && cnt < 200) begin
         cnt++;
         if (done) saw_done = 1'b1;
         tick;
      end
      if (done) saw_done = 1'b1;
      check_q("timeout_cycles", 16'(cnt), 16'd63);
      check1("timeout_err", err, 1'b1);
      check1("timeout_idle", busy, 1'b0);
      check1("timeout_no_done", saw_done, 1'b0);
      tick;
      check1("err_sticky", err, 1'b1);

      $display("[TB] restart and reset in LOAD");
      start = 1'b1;
      tick;
      start = 1'b0;
      check1("err_cleared", err, 1'b0);
      check1("restart_req", src_req, 1'b1);
      check_a("restart_addr", src_addr, 7'h00);
      run_pair(7'h00, 16'h0001, 16'h0001, 1'b0, 1'b0);
      run_pair(7'h01, 16'h0002, 16'h0002, 1'b0, 1'b0);
      check_a("pair3_addr", src_addr, 7'h08);
      tick;
      tick;
      src_valid = 1'b1;
      src_data  = {VEC_LEN{16'hC0DE}};
      tick;
      src_valid = 1'b0;
      check1("pair3_load", ch.dc_load, 1'b1);
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check1("mid_rst_src_req", src_req, 1'b0);
      check_a("mid_rst_src_addr", src_addr, 7'h00);
      check_v("mid_rst_d", ch.d, '0);
      check1("mid_rst_dc_load", ch.dc_load, 1'b0);
      check1("mid_rst_ws_load", ch.ws_load, 1'b0);
      check_a("mid_rst_idx", {ch.cs, ch.phase}, 7'h00);
      check1("mid_rst_res_valid", res_valid, 1'b0);
      check_q("mid_rst_res_data", res_data, 16'h0000);
      check_a("mid_rst_res_addr", res_addr, 7'h00);
      check1("mid_rst_busy", busy, 1'b0);
      check1("mid_rst_done", done, 1'b0);
      check1("mid_rst_err", err, 1'b0);
      tick;
      check1("post_rst_idle", busy, 1'b0);
      start = 1'b1;
      tick;
      start = 1'b0;
      check1("post_rst_req", src_req, 1'b1);
      check_a("post_rst_addr", src_addr, 7'h00);
      run_pair(7'h00, 16'h8001, neg_exp == 16'h0000 ? 16'h0000 : 16'h8001, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
